// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - UART receiver: 2-flop synchronizer, 16x oversampled 8N1/8E1 frame recovery
// Optional even-parity stage is compiled in when UART_RX_PARITY_EN is defined.
module uart_rx_core #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 rx_busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] TC_END  = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] TC_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [BW-1:0] BC_LAST = BW'(DATA_BITS - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;
`endif

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   r_sync0;
  logic                   r_sync1;
  logic                   w_rx_s;
  logic [TW-1:0]          r_tick_cnt;
  logic [BW-1:0]          r_bit_cnt;
  logic [DATA_BITS-1:0]   r_shift;
  logic [DATA_BITS-1:0]   r_data;
  logic                   r_valid;
  logic                   r_ferr;
  logic                   w_tick_clr;
  logic                   w_tick_inc;
  logic                   w_bit_clr;
  logic                   w_shift;
  logic                   w_done;
`ifdef UART_RX_PARITY_EN
  logic                   r_perr;
  logic                   w_par_load;
`endif

  assign w_rx_s = r_sync1;

  // Two-flop synchronizer; resets to the idle (high) line level
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync0 <= 1'b1;
      r_sync1 <= 1'b1;
    end else begin
      r_sync0 <= rx_in;
      r_sync1 <= r_sync0;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state and datapath control; nothing moves without a baud tick
  always_comb begin
    w_state_nxt = r_state;
    w_tick_clr  = 1'b0;
    w_tick_inc  = 1'b0;
    w_bit_clr   = 1'b0;
    w_shift     = 1'b0;
    w_done      = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_load  = 1'b0;
`endif
    if (baud_tick) begin
      case (r_state)
        IDLE: begin
          if (!w_rx_s) begin
            w_state_nxt = START;
            w_tick_clr  = 1'b1;
          end
        end
        START: begin
          if (r_tick_cnt == TC_HALF) begin
            if (!w_rx_s) begin
              w_state_nxt = DATA;
              w_tick_clr  = 1'b1;
              w_bit_clr   = 1'b1;
            end else begin
              w_state_nxt = IDLE;
            end
          end else begin
            w_tick_inc = 1'b1;
          end
        end
        DATA: begin
          if (r_tick_cnt == TC_END) begin
            w_shift    = 1'b1;
            w_tick_clr = 1'b1;
            if (r_bit_cnt == BC_LAST) begin
`ifdef UART_RX_PARITY_EN
              w_state_nxt = PARITY;
`else
              w_state_nxt = STOP;
`endif
            end
          end else begin
            w_tick_inc = 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (r_tick_cnt == TC_END) begin
            w_par_load  = 1'b1;
            w_tick_clr  = 1'b1;
            w_state_nxt = STOP;
          end else begin
            w_tick_inc = 1'b1;
          end
        end
`endif
        STOP: begin
          if (r_tick_cnt == TC_END) begin
            w_done      = 1'b1;
            w_tick_clr  = 1'b1;
            w_state_nxt = w_rx_s ? IDLE : BRK;
          end else begin
            w_tick_inc = 1'b1;
          end
        end
        BRK: begin
          // Wait out a held-low line so it cannot look like a new start bit
          if (w_rx_s) w_state_nxt = IDLE;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Tick/bit counters and LSB-first shift register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
    end else begin
      if (w_tick_clr)      r_tick_cnt <= '0;
      else if (w_tick_inc) r_tick_cnt <= r_tick_cnt + TW'(1);
      if (w_bit_clr)       r_bit_cnt  <= '0;
      else if (w_shift)    r_bit_cnt  <= r_bit_cnt + BW'(1);
      if (w_shift)         r_shift    <= {w_rx_s, r_shift[DATA_BITS-1:1]};
    end
  end

  // Output byte, one-clk valid strobe and sticky-until-next-frame error flags
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_valid <= w_done;
      if (w_done) begin
        r_data <= r_shift;
        r_ferr <= ~w_rx_s;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  // Even parity over data plus received parity bit
  always_ff @(posedge clk) begin
    if (rst) begin
      r_perr     <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (w_par_load) r_perr     <= w_rx_s ^ (^r_shift);
      if (w_done)     parity_err <= r_perr;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

  assign rx_data  = r_data;
  assign rx_valid = r_valid;
  assign frame_err = r_ferr;
  assign rx_busy  = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// tb/tb_uart_rx_core.sv - directed self-checking bench for uart_rx_core (either UART_RX_PARITY_EN build)
module tb_uart_rx_core;

  localparam int DATA_BITS = 8;
  localparam int OS        = 16;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       baud_tick;
  logic       rx_in;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       parity_err;
  logic       frame_err;
  logic       rx_busy;

  int n_checks  = 0;
  int n_errors  = 0;
  int valid_cnt = 0;
  logic [7:0] cap_data = 8'h00;
  logic       cap_perr = 1'b0;
  logic       cap_ferr = 1'b0;

  always #5 clk = ~clk;

  uart_rx_core #(.DATA_BITS(DATA_BITS), .OVERSAMPLE(OS)) dut (
    .clk        (clk),
    .rst        (rst),
    .baud_tick  (baud_tick),
    .rx_in      (rx_in),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .rx_busy    (rx_busy)
  );

  // Collect every valid strobe mid-cycle
  always @(negedge clk) begin
    if (rx_valid) begin
      valid_cnt <= valid_cnt + 1;
      cap_data  <= rx_data;
      cap_perr  <= parity_err;
      cap_ferr  <= frame_err;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_ticks(input int n);
    baud_tick = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    rx_in = b;
    run_ticks(OS);
  endtask

  // Frame with optional parity flip, chosen stop level, and a baud-tick freeze inside data bit freeze_bit
  task automatic send_frame(input logic [7:0] d, input bit flip, input logic stop, input int freeze_bit);
    int v0;
    send_bit(1'b0);
    for (int i = 0; i < DATA_BITS; i++) begin
      if (i == freeze_bit) begin
        rx_in = d[i];
        run_ticks(5);
        v0 = valid_cnt;
        baud_tick = 1'b0;
        repeat (50) @(negedge clk);
        check("freeze_busy", {31'd0, rx_busy}, 32'd1);
        check("freeze_novalid", valid_cnt, v0);
        run_ticks(OS - 5);
      end else begin
        send_bit(d[i]);
      end
    end
    if (PAR_EN) send_bit((^d) ^ flip);
    send_bit(stop);
  endtask

  task automatic expect_frame(input string tag, input int v_before, input logic [7:0] d,
                              input logic perr, input logic ferr);
    check({tag, "_cnt"},  valid_cnt, v_before + 1);
    check({tag, "_data"}, {24'd0, cap_data}, {24'd0, d});
    check({tag, "_perr"}, {31'd0, cap_perr}, {31'd0, perr});
    check({tag, "_ferr"}, {31'd0, cap_ferr}, {31'd0, ferr});
  endtask

  initial begin
    int v;
    rst = 1'b1;
    baud_tick = 1'b0;
    rx_in = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Idle line after reset
    run_ticks(100);
    check("idle_busy",  {31'd0, rx_busy},    32'd0);
    check("idle_valid", {31'd0, rx_valid},   32'd0);
    check("idle_data",  {24'd0, rx_data},    32'd0);
    check("idle_perr",  {31'd0, parity_err}, 32'd0);
    check("idle_ferr",  {31'd0, frame_err},  32'd0);
    check("idle_cnt",   valid_cnt,           0);

    // Clean frame
    v = valid_cnt;
    send_frame(8'h5E, 1'b0, 1'b1, -1);
    expect_frame("f5e", v, 8'h5E, 1'b0, 1'b0);
    check("f5e_idle", {31'd0, rx_busy}, 32'd0);

    // Wrong parity bit, then a good frame clears the flag
    v = valid_cnt;
    send_frame(8'h5F, 1'b1, 1'b1, -1);
    expect_frame("f5f", v, 8'h5F, PAR_EN, 1'b0);
    v = valid_cnt;
    send_frame(8'hA5, 1'b0, 1'b1, -1);
    expect_frame("fa5", v, 8'hA5, 1'b0, 1'b0);

    // Framing error followed by a held break
    v = valid_cnt;
    send_frame(8'h3C, 1'b0, 1'b0, -1);
    run_ticks(40);
    expect_frame("f3c", v, 8'h3C, 1'b0, 1'b1);
    check("brk_busy", {31'd0, rx_busy}, 32'd1);
    rx_in = 1'b1;
    run_ticks(4);
    check("brk_exit", {31'd0, rx_busy}, 32'd0);
    check("brk_nomore", valid_cnt, v + 1);
    run_ticks(OS);
    v = valid_cnt;
    send_frame(8'h81, 1'b0, 1'b1, -1);
    expect_frame("f81", v, 8'h81, 1'b0, 1'b0);

    // Start-bit glitch
    v = valid_cnt;
    rx_in = 1'b0;
    run_ticks(4);
    rx_in = 1'b1;
    run_ticks(3);
    check("glitch_start", {31'd0, rx_busy}, 32'd1);
    run_ticks(20);
    check("glitch_idle", {31'd0, rx_busy}, 32'd0);
    check("glitch_novalid", valid_cnt, v);

    // Reset during data bit 3 of 0xFF
    v = valid_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    run_ticks(5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_busy",  {31'd0, rx_busy},    32'd0);
    check("rst_valid", {31'd0, rx_valid},   32'd0);
    check("rst_data",  {24'd0, rx_data},    32'd0);
    check("rst_perr",  {31'd0, parity_err}, 32'd0);
    check("rst_ferr",  {31'd0, frame_err},  32'd0);
    run_ticks(120);
    check("rst_novalid", valid_cnt, v);
    check("rst_idle", {31'd0, rx_busy}, 32'd0);

    // Baud tick held low mid-frame freezes the receiver
    v = valid_cnt;
    send_frame(8'hC3, 1'b0, 1'b1, 4);
    expect_frame("fc3", v, 8'hC3, 1'b0, 1'b0);

    // Back-to-back frames with no idle gap
    v = valid_cnt;
    send_frame(8'h00, 1'b0, 1'b1, -1);
    expect_frame("b00", v, 8'h00, 1'b0, 1'b0);
    v = valid_cnt;
    send_frame(8'hFF, 1'b0, 1'b1, -1);
    expect_frame("bff", v, 8'hFF, 1'b0, 1'b0);
    v = valid_cnt;
    send_frame(8'h55, 1'b0, 1'b1, -1);
    expect_frame("b55", v, 8'h55, 1'b0, 1'b0);
    run_ticks(OS);
    check("final_idle", {31'd0, rx_busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
